// File: rtl/bayer_to_gray.sv
// Bayer-quad to grey converter: averages each 2x2 R/G1/G2/B quad into one grey pixel.
// Define BAYER_TO_GRAY_MIRROR_EN to emit horizontally mirrored gray_x.
module bayer_to_gray #(
    parameter int RAW_WIDTH  = 2560,
    parameter int RAW_HEIGHT = 1920,
    parameter int DATA_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic              raw_valid,
    input  logic [DATA_W-1:0] raw_data,
    output logic              gray_valid,
    output logic [DATA_W-1:0] gray_data,
    output logic [10:0]       gray_x,
    output logic [10:0]       gray_y,
    output logic              frame_done
);

    // state    | meaning
    // IDLE     | waiting for sof, raw samples ignored
    // EVEN_ROW | storing the R/G1 row into the line buffer
    // ODD_ROW  | pairing G2/B samples with the stored row, emitting grey pixels
    typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW} state_t;

    localparam int COL_W = (RAW_WIDTH > 2) ? $clog2(RAW_WIDTH) : 1;
    localparam int ROW_W = (RAW_HEIGHT > 2) ? $clog2(RAW_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(RAW_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(RAW_HEIGHT - 1);

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [DATA_W-1:0]  r_hold;
    logic [DATA_W-1:0]  g2_hold;

    logic [DATA_W-1:0]  line_buf [RAW_WIDTH];
    logic [COL_W-1:0]   buf_addr;
    logic               buf_we;
    logic [DATA_W-1:0]  buf_rd;

    logic [DATA_W-1:0]  gray_next;
    logic [10:0]        x_next;
    logic               final_wrap;

    // Single port: written only in EVEN_ROW (or the first sample under sof), read only in ODD_ROW.
    // Asynchronous read so the stored G1/R is usable in the same cycle as the raw sample.
    assign buf_we   = raw_valid && (sof || state == EVEN_ROW);
    assign buf_addr = sof ? '0 : col;
    assign buf_rd   = line_buf[buf_addr];

    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[buf_addr] <= raw_data;
        end
    end

    assign gray_next = DATA_W'(({2'b00, r_hold} + {2'b00, buf_rd} +
                                {2'b00, g2_hold} + {2'b00, raw_data}) >> 2);

`ifdef BAYER_TO_GRAY_MIRROR_EN
    assign x_next = 11'(RAW_WIDTH / 2 - 1) - 11'(col >> 1);
`else
    assign x_next = 11'(col >> 1);
`endif

    assign final_wrap = raw_valid && state == ODD_ROW && col == COL_LAST && row == ROW_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            r_hold     <= '0;
            g2_hold    <= '0;
            gray_valid <= 1'b0;
            gray_data  <= '0;
            gray_x     <= '0;
            gray_y     <= '0;
            frame_done <= 1'b0;
        end else begin
            gray_valid <= 1'b0;
            frame_done <= final_wrap;
            if (sof) begin
                // The sample arriving with sof is pixel 0 of the new frame.
                state <= EVEN_ROW;
                row   <= '0;
                col   <= raw_valid ? COL_W'(1) : '0;
            end else if (raw_valid && state != IDLE) begin
                if (state == ODD_ROW) begin
                    if (!col[0]) begin
                        r_hold  <= buf_rd;
                        g2_hold <= raw_data;
                    end else begin
                        gray_valid <= 1'b1;
                        gray_data  <= gray_next;
                        gray_x     <= x_next;
                        gray_y     <= 11'(row >> 1);
                    end
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    if (state == EVEN_ROW) begin
                        state <= ODD_ROW;
                        row   <= row + ROW_W'(1);
                    end else if (row == ROW_LAST) begin
                        state <= IDLE;
                    end else begin
                        state <= EVEN_ROW;
                        row   <= row + ROW_W'(1);
                    end
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule
